// File: rtl/button_conditioner.sv
// Per-channel input conditioner: 2-flop synchronizer, debounce FSM and
// registered level / rising-edge / falling-edge outputs.
module button_conditioner #(
  parameter int unsigned NUM_INPUTS      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  localparam int unsigned CNT_WIDTH      = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse
);

  typedef enum logic [1:0] {
    StStableLow,
    StCheckHigh,
    StStableHigh,
    StCheckLow
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    logic                 sync1_q, sync2_q;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, rise_q, fall_q;
    logic                 level_d, rise_d, fall_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw_in[i];
        sync2_q <= sync1_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StStableLow;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Any sample disagreeing with the candidate level abandons the check.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
        StStableLow: begin
          if (sync2_q) begin
            state_d = StCheckHigh;
            cnt_d   = CntOne;
          end
        end
        StCheckHigh: begin
          if (!sync2_q) begin
            state_d = StStableLow;
          end else if (cnt_q == CntMax) begin
            state_d = StStableHigh;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StStableHigh: begin
          if (!sync2_q) begin
            state_d = StCheckLow;
            cnt_d   = CntOne;
          end
        end
        StCheckLow: begin
          if (sync2_q) begin
            state_d = StStableHigh;
          end else if (cnt_q == CntMax) begin
            state_d = StStableLow;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StStableLow;
        end
      endcase
    end

    // Accepted level follows the FSM; pulses mark changes of the registered level.
    always_comb begin
      level_d = (state_q == StStableHigh) || (state_q == StCheckLow);
      rise_d  = level_d & ~level_q;
      fall_d  = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign level_out[i]  = level_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, two channels.
module tb_button_conditioner;

  localparam int unsigned Lat = 7;  // drive at negedge N -> outputs after edge N+7

  logic       clk;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] level_out, rise_pulse, fall_pulse;

  button_conditioner #(
    .NUM_INPUTS     (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  typedef struct {
    int unsigned cyc;
    logic [1:0]  level;
    logic [1:0]  rise;
    logic [1:0]  fall;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expected event, and no
  // expected event may go overdue.
  always @(negedge clk) begin
    if ((rise_pulse | fall_pulse) != 2'b00) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc %0d rise %b fall %b level %b, none expected",
                 cyc, rise_pulse, fall_pulse, level_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.level !== level_out || e.rise !== rise_pulse ||
            e.fall !== fall_pulse) begin
          n_fail++;
          $display("FAIL pulse_event: got cyc %0d level %b rise %b fall %b, expected cyc %0d level %b rise %b fall %b",
                   cyc, level_out, rise_pulse, fall_pulse, e.cyc, e.level, e.rise, e.fall);
        end
      end
    end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: got no pulse by cyc %0d, expected cyc %0d rise %b fall %b",
               cyc, e.cyc, e.rise, e.fall);
    end
  end

  task automatic expect_event(input logic [1:0] level, input logic [1:0] rise,
                              input logic [1:0] fall);
    exp_t e;
    e.cyc   = cyc + Lat;
    e.level = level;
    e.rise  = rise;
    e.fall  = fall;
    sb_q.push_back(e);
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 2'b11;

    // Reset held 3 cycles with inputs high: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check2("reset_level", level_out, 2'b00);
      check2("reset_pulses", rise_pulse | fall_pulse, 2'b00);
    end
    reset = 1'b0;
    expect_event(2'b11, 2'b11, 2'b00);
    wait_neg(10);
    check2("post_reset_level", level_out, 2'b11);

    raw_in = 2'b00;
    expect_event(2'b00, 2'b00, 2'b11);
    wait_neg(10);
    check2("idle_level", level_out, 2'b00);

    // Clean step on channel 0 only.
    raw_in = 2'b01;
    expect_event(2'b01, 2'b01, 2'b00);
    wait_neg(10);
    check2("ch0_step_level", level_out, 2'b01);
    raw_in = 2'b00;
    expect_event(2'b00, 2'b00, 2'b01);
    wait_neg(10);

    // Three-cycle glitch on channel 0 is rejected.
    raw_in = 2'b01;
    wait_neg(3);
    raw_in = 2'b00;
    wait_neg(12);
    check2("glitch_level", level_out, 2'b00);

    // Bouncing release on channel 1.
    raw_in = 2'b10;
    expect_event(2'b10, 2'b10, 2'b00);
    wait_neg(10);
    raw_in = 2'b00;
    wait_neg(2);
    raw_in = 2'b10;
    wait_neg(2);
    raw_in = 2'b00;
    expect_event(2'b00, 2'b00, 2'b10);
    wait_neg(10);
    check2("bounce_level", level_out, 2'b00);

    // Reset while channel 0 sits in CHECK_HIGH with counter 2.
    raw_in = 2'b01;
    wait_neg(4);
    reset = 1'b1;
    wait_neg(1);
    check2("midreset_level", level_out, 2'b00);
    check2("midreset_pulses", rise_pulse | fall_pulse, 2'b00);
    reset = 1'b0;
    expect_event(2'b01, 2'b01, 2'b00);
    wait_neg(10);
    check2("midreset_recover_level", level_out, 2'b01);
    raw_in = 2'b00;
    expect_event(2'b00, 2'b00, 2'b01);
    wait_neg(10);

    // Simultaneous steps on both channels, then release channel 1 only.
    raw_in = 2'b11;
    expect_event(2'b11, 2'b11, 2'b00);
    wait_neg(10);
    raw_in = 2'b01;
    expect_event(2'b01, 2'b00, 2'b10);
    wait_neg(12);
    check2("final_level", level_out, 2'b01);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending events expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input conditioning stage that sits directly upstream of the stopwatch top level.
- Takes asynchronous board inputs (reset push-button, hold-count slide switch) and produces clean, clock-domain-synchronous signals.
- Each channel outputs a debounced level, a one-cycle rising-edge pulse and a one-cycle falling-edge pulse, which drive the stopwatch's reset and hold inputs.
- Channels are independent copies of the same synchronizer + debounce FSM.

Parameters:
- NUM_INPUTS, 2, number of independent input channels (bit 0 = reset button, bit 1 = hold switch by convention of the top level).
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronized samples required to accept a change; 10 ms at 100 MHz; legal range >= 2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), width of each per-channel debounce counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  NUM_INPUTS  asynchronous raw button/switch inputs, active-high.
- level_out  output  NUM_INPUTS  debounced level per channel.
- rise_pulse  output  NUM_INPUTS  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  NUM_INPUTS  one-cycle pulse when level_out goes 1->0.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset state, applied on any clk edge with reset=1, all channels:
  - sync flops = 0; state = STABLE_LOW; counter = 0.
  - level_out = 0; rise_pulse = 0; fall_pulse = 0.
- Reset overrides everything, including mid-debounce. An in-progress count is discarded and no pulse is emitted.
- Synchronizer: 2-flop chain per channel, sync1 <= raw_in[i] and sync2 <= sync1. The FSM looks only at sync2.
- FSM per channel, states STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW:
  - STABLE_LOW: sync2=1 -> CHECK_HIGH, counter=1; otherwise stay, counter=0.
  - CHECK_HIGH:
    - sync2=0 -> STABLE_LOW, counter=0, no output change.
    - sync2=1 and counter==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level_out=1, rise_pulse=1 for that one cycle, counter=0.
    - Otherwise counter+1.
  - STABLE_HIGH and CHECK_LOW: mirror images of the above, with fall_pulse.
- Pulses are registered, high for exactly one clk cycle, and cleared in every other cycle. rise_pulse and fall_pulse are never both high on the same channel.
- Latency: let E0 be the first clk edge that samples a new raw value, held stable thereafter. level_out and the pulse update at edge E0+DEBOUNCE_CYCLES+2.
- Glitch rejection: a sync2 excursion lasting fewer than DEBOUNCE_CYCLES cycles produces no output change and no pulse. The counter restarts from 0 on the next excursion.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- raw_in already high when reset deasserts: the channel debounces normally from STABLE_LOW and emits one rise_pulse after the full latency.
- Channels share nothing except clk and reset. Simultaneous events on different channels are handled independently, in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, NUM_INPUTS=2):
- Reset held 3 cycles with raw_in=2'b11 -> level_out=0, pulses=0 throughout reset. After release, level_out=2'b11 and rise_pulse=2'b11 for exactly one cycle at edge E0+6, where E0 is the first edge after reset release.
- raw_in[0] 0->1 clean step from idle -> level_out[0]=1 and rise_pulse[0]=1 at edge E0+6, rise_pulse[0]=0 at E0+7. Channel 1 outputs unchanged.
- raw_in[0] pulse high for 3 cycles, then low -> no change on level_out[0]; rise_pulse[0] and fall_pulse[0] stay 0.
- Bouncing release: raw_in[1] high->low->high->low with 2-cycle segments, then held low -> exactly one fall_pulse[1], at final-low E0+6; level_out[1] 1->0 once.
- Reset asserted while channel 0 is in CHECK_HIGH with counter=2 -> next cycle: state STABLE_LOW, counter 0, no rise_pulse. After release with raw still high, rise_pulse occurs 6 edges later.
- Both channels stepped on the same edge (raw_in 2'b00->2'b11) -> rise_pulse=2'b11 on the same cycle. Later, step raw_in 2'b11->2'b01 -> fall_pulse=2'b10 only.
